// File: rtl/sync_long_sched.sv
// Long-preamble sequencer: bounded first-peak search, second-peak verification,
// then CP removal and valid/start/last framing of the OFDM symbol stream.
module sync_long_sched #(
  parameter int CW           = 10,
  parameter int SEARCH_LEN   = 64,
  parameter int PEAK_SPACING = 64,
  parameter int DATA_OFFSET  = 128,
  parameter int MAG_LAT      = 3
) (
  input  logic          CLK,
  input  logic          s_RST,
  input  logic          input_strobe,
  input  logic          short_preamble_found,
  input  logic          abort,
  input  logic          mag_strobe,
  input  logic [11:0]   Mag_Sq,
  input  logic [11:0]   threshold,
  input  logic [7:0]    num_symbols,
  output logic          busy,
  output logic [CW-1:0] peak_index,
  output logic          peak_found,
  output logic          sync_fail,
  output logic          fft_valid,
  output logic          sym_start,
  output logic          sym_last,
  output logic [7:0]    sym_count,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_VERIFY,
    S_WAIT_DATA,
    S_STREAM
  } state_e;

  // All index arithmetic is modulo 2^CW, so the offsets are folded to CW bits.
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] EXIT_CNT  = CW'(SEARCH_LEN + MAG_LAT);
  localparam logic [CW-1:0] LAT_C     = CW'(MAG_LAT);
  localparam logic [CW-1:0] SPACING_C = CW'(PEAK_SPACING);
  localparam logic [CW-1:0] OFFSET_C  = CW'(DATA_OFFSET);
  localparam logic [6:0]    CP_LEN    = 7'd16;
  localparam logic [6:0]    SYM_END   = 7'd79;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [11:0]   max_q;
  logic [7:0]    nsym_q;
  logic [6:0]    pos_q;
  logic          busy_q;
  logic [CW-1:0] peak_index_q;
  logic          peak_found_q;
  logic          sync_fail_q;
  logic          fft_valid_q;
  logic          sym_start_q;
  logic          sym_last_q;
  logic [7:0]    sym_count_q;
  logic          done_q;

  logic [CW-1:0] tidx;
  logic [7:0]    sym_next;

  assign tidx     = cnt_q - LAT_C;
  assign sym_next = sym_count_q + 8'd1;

  always_ff @(posedge CLK or negedge s_RST) begin
    if (!s_RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      max_q        <= '0;
      nsym_q       <= '0;
      pos_q        <= '0;
      busy_q       <= 1'b0;
      peak_index_q <= '0;
      peak_found_q <= 1'b0;
      sync_fail_q  <= 1'b0;
      fft_valid_q  <= 1'b0;
      sym_start_q  <= 1'b0;
      sym_last_q   <= 1'b0;
      sym_count_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only by the event
      // that qualifies them; later non-blocking writes in this block override.
      peak_found_q <= 1'b0;
      sync_fail_q  <= 1'b0;
      fft_valid_q  <= 1'b0;
      sym_start_q  <= 1'b0;
      sym_last_q   <= 1'b0;
      done_q       <= 1'b0;

      if (input_strobe) cnt_q <= cnt_q + ONE_C;

      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (short_preamble_found) begin
              cnt_q        <= '0;
              max_q        <= '0;
              peak_index_q <= '0;
              nsym_q       <= num_symbols;
              sym_count_q  <= '0;
              if (num_symbols == 8'd0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_SEARCH;
                busy_q  <= 1'b1;
              end
            end
          end

          S_SEARCH: begin
            // The window closes once the last in-window magnitude has arrived.
            if (cnt_q == EXIT_CNT) begin
              if (max_q < threshold) begin
                sync_fail_q <= 1'b1;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
              end else begin
                state_q <= S_VERIFY;
              end
            end else if (mag_strobe && (Mag_Sq > max_q)) begin
              max_q        <= Mag_Sq;
              peak_index_q <= tidx;
            end
          end

          S_VERIFY: begin
            if (mag_strobe && (tidx == peak_index_q + SPACING_C)) begin
              if (Mag_Sq >= threshold) begin
                peak_found_q <= 1'b1;
                state_q      <= S_WAIT_DATA;
              end else begin
                sync_fail_q <= 1'b1;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
              end
            end
          end

          S_WAIT_DATA: begin
            // The triggering sample is CP position 0; pos_q holds the position
            // of the next sample to arrive.
            if (input_strobe && (cnt_q == peak_index_q + OFFSET_C)) begin
              pos_q   <= 7'd1;
              state_q <= S_STREAM;
            end
          end

          S_STREAM: begin
            if (input_strobe) begin
              fft_valid_q <= (pos_q >= CP_LEN);
              sym_start_q <= (pos_q == CP_LEN);
              sym_last_q  <= (pos_q == SYM_END);
              if (pos_q == SYM_END) begin
                pos_q       <= '0;
                sym_count_q <= sym_next;
                if (sym_next == nsym_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                pos_q <= pos_q + 7'd1;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign peak_index = peak_index_q;
  assign peak_found = peak_found_q;
  assign sync_fail  = sync_fail_q;
  assign fft_valid  = fft_valid_q;
  assign sym_start  = sym_start_q;
  assign sym_last   = sym_last_q;
  assign sym_count  = sym_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sync_long_sched.sv
// Self-checking bench for sync_long_sched: table-driven scenarios with a per-cycle
// scoreboard, plus hand-written reset, zero-symbol and counter-wrap sequences.
module tb_sync_long_sched;

  localparam int CW           = 10;
  localparam int SEARCH_LEN   = 64;
  localparam int PEAK_SPACING = 64;
  localparam int DATA_OFFSET  = 128;
  localparam int MAG_LAT      = 3;

  logic        CLK = 1'b0;
  logic        s_RST;
  logic        input_strobe, short_preamble_found, abort, mag_strobe;
  logic [11:0] Mag_Sq, threshold;
  logic [7:0]  num_symbols;

  logic          busy, peak_found, sync_fail, fft_valid, sym_start, sym_last, done;
  logic [CW-1:0] peak_index;
  logic [7:0]    sym_count;

  logic       w_busy, w_peak_found, w_sync_fail, w_fft_valid, w_sym_start, w_sym_last, w_done;
  logic [6:0] w_peak_index;
  logic [7:0] w_sym_count;

  always #5 CLK = ~CLK;

  sync_long_sched #(
    .CW(CW), .SEARCH_LEN(SEARCH_LEN), .PEAK_SPACING(PEAK_SPACING),
    .DATA_OFFSET(DATA_OFFSET), .MAG_LAT(MAG_LAT)
  ) u_dut (
    .CLK(CLK), .s_RST(s_RST), .input_strobe(input_strobe),
    .short_preamble_found(short_preamble_found), .abort(abort),
    .mag_strobe(mag_strobe), .Mag_Sq(Mag_Sq), .threshold(threshold),
    .num_symbols(num_symbols), .busy(busy), .peak_index(peak_index),
    .peak_found(peak_found), .sync_fail(sync_fail), .fft_valid(fft_valid),
    .sym_start(sym_start), .sym_last(sym_last), .sym_count(sym_count), .done(done)
  );

  // Narrow counter with a long window so the second peak and data start wrap.
  sync_long_sched #(
    .CW(7), .SEARCH_LEN(120), .PEAK_SPACING(64), .DATA_OFFSET(128), .MAG_LAT(3)
  ) u_wrap (
    .CLK(CLK), .s_RST(s_RST), .input_strobe(input_strobe),
    .short_preamble_found(short_preamble_found), .abort(abort),
    .mag_strobe(mag_strobe), .Mag_Sq(Mag_Sq), .threshold(threshold),
    .num_symbols(num_symbols), .busy(w_busy), .peak_index(w_peak_index),
    .peak_found(w_peak_found), .sync_fail(w_sync_fail), .fft_valid(w_fft_valid),
    .sym_start(w_sym_start), .sym_last(w_sym_last), .sym_count(w_sym_count), .done(w_done)
  );

  typedef struct packed {
    logic busy;
    logic peak_found;
    logic sync_fail;
    logic fft_valid;
    logic sym_start;
    logic sym_last;
    logic done;
  } flags_t;

  typedef struct {
    int peak_t;   int peak_mag; int ver_mag; int thr;
    int tie_t;    int flat;     int gap;     int nsym;
    int abort_k;  int arm_k;
    int exp_pi;   int exp_pf;   int exp_sf;  int exp_fft;
    int exp_symc; int exp_done;
  } case_t;

  case_t  cases[8];
  flags_t sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic flags_t dut_flags();
    flags_t f;
    f = {busy, peak_found, sync_fail, fft_valid, sym_start, sym_last, done};
    return f;
  endfunction

  task automatic drive(input bit is, input bit spf, input bit ab, input bit ms, input int mag);
    input_strobe         = is;
    short_preamble_found = spf;
    abort                = ab;
    mag_strobe           = ms;
    Mag_Sq               = 12'(mag);
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input bit is, input bit spf, input bit ab, input bit ms, input int mag,
                      input flags_t e, input string name);
    flags_t x;
    sb_q.push_back(e);
    drive(is, spf, ab, ms, mag);
    x = sb_q.pop_front();
    check(name, 32'(dut_flags()), 32'(x));
  endtask

  function automatic int mag_of(input case_t c, input int t);
    if (c.flat != 0) return c.peak_mag;
    if (t == c.peak_t || t == c.tie_t) return c.peak_mag;
    if (t == c.peak_t + PEAK_SPACING) return c.ver_mag;
    return t % 37;
  endfunction

  task automatic run_case(input int id, input case_t c);
    int pidx, ver_k, start_k, stop_k, n, p, cnt_pre;
    int pf_n, sf_n, fft_n, done_n;
    bit search_ok, verify_ok, exit_done, ended, smp, ab;
    flags_t e;
    pidx      = (c.flat != 0) ? 0 : c.peak_t;
    search_ok = c.peak_mag >= c.thr;
    verify_ok = search_ok && (c.ver_mag >= c.thr);
    ver_k     = pidx + PEAK_SPACING + MAG_LAT;
    start_k   = pidx + DATA_OFFSET;
    stop_k    = start_k + 80 * c.nsym;
    n         = verify_ok ? stop_k + 4 : 120;
    threshold   = 12'(c.thr);
    num_symbols = 8'(c.nsym);
    pf_n = 0; sf_n = 0; fft_n = 0; done_n = 0;
    e = '0;
    e.busy = 1'b1;
    step(0, 1, 0, 0, 0, e, $sformatf("c%0d arm", id));
    exit_done = 0;
    ended     = 0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g <= c.gap; g++) begin
        cnt_pre = k + g;
        smp     = (g == 0);
        ab      = smp && (k == c.abort_k);
        e       = '0;
        if (!ended) begin
          if (ab) begin
            ended = 1;
          end else begin
            if (!exit_done && cnt_pre == SEARCH_LEN + MAG_LAT) begin
              exit_done = 1;
              if (!search_ok) begin e.sync_fail = 1'b1; ended = 1; end
            end
            if (smp && exit_done && search_ok && k == ver_k) begin
              if (verify_ok) e.peak_found = 1'b1;
              else begin e.sync_fail = 1'b1; ended = 1; end
            end
            if (smp && verify_ok && k >= start_k && k < stop_k) begin
              p = (k - start_k) % 80;
              e.fft_valid = (p >= 16);
              e.sym_start = (p == 16);
              e.sym_last  = (p == 79);
              if (k == stop_k - 1) begin e.done = 1'b1; ended = 1; end
            end
          end
        end
        e.busy = !ended;
        step(smp, smp && (k == c.arm_k), ab, smp && (k >= MAG_LAT),
             smp ? mag_of(c, k - MAG_LAT) : 0, e, $sformatf("c%0d k%0d g%0d", id, k, g));
        pf_n   += int'(peak_found);
        sf_n   += int'(sync_fail);
        fft_n  += int'(fft_valid);
        done_n += int'(done);
      end
    end
    check($sformatf("c%0d peak_index", id), 32'(peak_index), 32'(c.exp_pi));
    check($sformatf("c%0d peak_found count", id), 32'(pf_n), 32'(c.exp_pf));
    check($sformatf("c%0d sync_fail count", id), 32'(sf_n), 32'(c.exp_sf));
    check($sformatf("c%0d fft_valid count", id), 32'(fft_n), 32'(c.exp_fft));
    check($sformatf("c%0d sym_count", id), 32'(sym_count), 32'(c.exp_symc));
    check($sformatf("c%0d done count", id), 32'(done_n), 32'(c.exp_done));
  endtask

  initial begin
    int first_fft, fft_n, start_n, last_at, pf_at, done_n, mag;
    flags_t e;

    cases[0] = '{peak_t:20, peak_mag:500, ver_mag:480, thr:100, tie_t:-1, flat:0, gap:0, nsym:2,
                 abort_k:-1, arm_k:-1, exp_pi:20, exp_pf:1, exp_sf:0, exp_fft:128, exp_symc:2, exp_done:1};
    cases[1] = '{peak_t:0, peak_mag:50, ver_mag:50, thr:100, tie_t:-1, flat:1, gap:0, nsym:2,
                 abort_k:-1, arm_k:-1, exp_pi:0, exp_pf:0, exp_sf:1, exp_fft:0, exp_symc:0, exp_done:0};
    cases[2] = '{peak_t:20, peak_mag:500, ver_mag:40, thr:100, tie_t:-1, flat:0, gap:0, nsym:2,
                 abort_k:-1, arm_k:-1, exp_pi:20, exp_pf:0, exp_sf:1, exp_fft:0, exp_symc:0, exp_done:0};
    cases[3] = '{peak_t:10, peak_mag:300, ver_mag:300, thr:100, tie_t:30, flat:0, gap:0, nsym:1,
                 abort_k:-1, arm_k:217, exp_pi:10, exp_pf:1, exp_sf:0, exp_fft:64, exp_symc:1, exp_done:1};
    cases[4] = '{peak_t:45, peak_mag:900, ver_mag:100, thr:100, tie_t:-1, flat:0, gap:1, nsym:1,
                 abort_k:-1, arm_k:-1, exp_pi:45, exp_pf:1, exp_sf:0, exp_fft:64, exp_symc:1, exp_done:1};
    cases[5] = '{peak_t:5, peak_mag:700, ver_mag:700, thr:200, tie_t:-1, flat:0, gap:0, nsym:3,
                 abort_k:253, arm_k:-1, exp_pi:5, exp_pf:1, exp_sf:0, exp_fft:88, exp_symc:1, exp_done:0};
    cases[6] = '{peak_t:63, peak_mag:150, ver_mag:150, thr:150, tie_t:-1, flat:0, gap:0, nsym:1,
                 abort_k:-1, arm_k:-1, exp_pi:63, exp_pf:1, exp_sf:0, exp_fft:64, exp_symc:1, exp_done:1};
    cases[7] = '{peak_t:30, peak_mag:99, ver_mag:500, thr:100, tie_t:-1, flat:0, gap:0, nsym:1,
                 abort_k:-1, arm_k:-1, exp_pi:30, exp_pf:0, exp_sf:1, exp_fft:0, exp_symc:0, exp_done:0};

    s_RST = 1'b0;
    input_strobe = 0; short_preamble_found = 0; abort = 0; mag_strobe = 0;
    Mag_Sq = '0; threshold = '0; num_symbols = '0;
    #12;
    check("reset flags", 32'(dut_flags()), 32'd0);
    check("reset peak_index", 32'(peak_index), 32'd0);
    check("reset sym_count", 32'(sym_count), 32'd0);
    #3 s_RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 8; i++) run_case(i, cases[i]);

    // Zero symbols: done pulse without ever leaving IDLE.
    threshold = 12'd100;
    num_symbols = 8'd0;
    e = '0;
    e.done = 1'b1;
    step(0, 1, 0, 0, 0, e, "nsym0 arm");
    e = '0;
    step(0, 0, 0, 0, 0, e, "nsym0 after");
    check("nsym0 sym_count", 32'(sym_count), 32'd0);

    // Asynchronous reset in the middle of symbol 1.
    num_symbols = 8'd2;
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k <= 258; k++)
      drive(1, 0, 0, k >= MAG_LAT, mag_of(cases[0], k - MAG_LAT));
    check("midstream fft_valid", 32'(fft_valid), 32'd1);
    check("midstream sym_count", 32'(sym_count), 32'd1);
    input_strobe = 0; mag_strobe = 0;
    #2 s_RST = 1'b0;
    #1;
    check("async reset flags", 32'(dut_flags()), 32'd0);
    check("async reset peak_index", 32'(peak_index), 32'd0);
    check("async reset sym_count", 32'(sym_count), 32'd0);
    #3 s_RST = 1'b1;

    // Counter wrap on the 7-bit instance: peak at 100, stream CP starts at cnt 100.
    threshold = 12'd200;
    num_symbols = 8'd1;
    drive(0, 1, 0, 0, 0);
    first_fft = -1; fft_n = 0; start_n = 0; last_at = -1; pf_at = -1; done_n = 0;
    for (int n = 0; n < 320; n++) begin
      mag = (n - 3 == 100 || n - 3 == 164) ? 800 : 10;
      drive(1, 0, 0, n >= 3, mag);
      if (w_peak_found) pf_at = n;
      if (w_fft_valid) begin
        if (first_fft < 0) first_fft = n;
        fft_n++;
      end
      if (w_sym_start) start_n++;
      if (w_sym_last) last_at = n;
      if (w_done) done_n++;
    end
    check("wrap peak_index", 32'(w_peak_index), 32'd100);
    check("wrap peak_found sample", 32'(pf_at), 32'd167);
    check("wrap first fft sample", 32'(first_fft), 32'd244);
    check("wrap fft count", 32'(fft_n), 32'd64);
    check("wrap sym_start count", 32'(start_n), 32'd1);
    check("wrap sym_last sample", 32'(last_at), 32'd307);
    check("wrap done count", 32'(done_n), 32'd1);
    check("wrap sym_count", 32'(w_sym_count), 32'd1);
    check("wrap busy end", 32'(w_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
